// File: rtl/seg_scan_decoder.sv
// Recovers a 4-digit hex value from a multiplexed, active-low 7-segment display scan.
// Each scan slot is captured once after its inputs have been stable for SETTLE sampled cycles.
module seg_scan_decoder #(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  anode,
  input  logic [6:0]  cathode,
  output logic [15:0] frame_value,
  output logic        frame_done,
  output logic [3:0]  digit_valid,
  output logic        pattern_err,
  output logic        seq_err
);

  typedef enum logic {HUNT, COLLECT} state_t;

  localparam logic [7:0] SETTLE_C  = 8'(SETTLE);
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

  logic [7:0] anode_m, anode_s, anode_p;
  logic [6:0] cathode_m, cathode_s, cathode_p;
  logic [7:0] cnt;
  logic       slot_done;
  logic       stable, settled;

  state_t          state, state_n;
  logic [1:0]      expd, expd_n;
  logic [3:0][3:0] nib, nib_n;
  logic [3:0]      dv_n;
  logic [15:0]     fv_n;
  logic            fd_n, pe_n, se_n;

  logic       legal, glyph_ok;
  logic [1:0] digit;
  logic [3:0] glyph;

  assign stable  = ({anode_s, cathode_s} == {anode_p, cathode_p});
  // The SETTLE-th consecutive stable cycle; slot_done blocks a second capture in the same slot.
  assign settled = stable && (cnt == SETTLE_M1) && !slot_done && (anode_s != 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_m   <= 8'hFF;
      anode_s   <= 8'hFF;
      anode_p   <= 8'hFF;
      cathode_m <= 7'h7F;
      cathode_s <= 7'h7F;
      cathode_p <= 7'h7F;
      cnt       <= 8'd0;
      slot_done <= 1'b0;
    end else begin
      anode_m   <= anode;
      anode_s   <= anode_m;
      anode_p   <= anode_s;
      cathode_m <= cathode;
      cathode_s <= cathode_m;
      cathode_p <= cathode_s;
      if (!stable || anode_s == 8'hFF) cnt <= 8'd0;
      else if (cnt != SETTLE_C)        cnt <= cnt + 8'd1;
      if (anode_s != anode_p) slot_done <= 1'b0;
      else if (settled)       slot_done <= 1'b1;
    end
  end

  always_comb begin
    legal = 1'b1;
    digit = 2'd0;
    case (anode_s)
      8'hFE:   digit = 2'd0;
      8'hFD:   digit = 2'd1;
      8'hFB:   digit = 2'd2;
      8'hF7:   digit = 2'd3;
      default: legal = 1'b0;
    endcase
    glyph_ok = 1'b1;
    glyph    = 4'h0;
    case (~cathode_s)
      7'h3F: glyph = 4'h0;
      7'h06: glyph = 4'h1;
      7'h5B: glyph = 4'h2;
      7'h4F: glyph = 4'h3;
      7'h66: glyph = 4'h4;
      7'h6D: glyph = 4'h5;
      7'h7D: glyph = 4'h6;
      7'h07: glyph = 4'h7;
      7'h7F: glyph = 4'h8;
      7'h6F: glyph = 4'h9;
      7'h77: glyph = 4'hA;
      7'h7C: glyph = 4'hB;
      7'h39: glyph = 4'hC;
      7'h5E: glyph = 4'hD;
      7'h79: glyph = 4'hE;
      7'h71: glyph = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    expd_n  = expd;
    nib_n   = nib;
    dv_n    = digit_valid;
    fv_n    = frame_value;
    fd_n    = 1'b0;
    pe_n    = 1'b0;
    se_n    = 1'b0;
    if (settled) begin
      if (!legal) begin
        se_n    = 1'b1;
        dv_n    = 4'b0000;
        state_n = HUNT;
      end else if (!glyph_ok) begin
        pe_n    = 1'b1;
        dv_n    = 4'b0000;
        state_n = HUNT;
      end else if (state == COLLECT && digit == expd) begin
        nib_n[digit]       = glyph;
        dv_n[digit]        = 1'b1;
        expd_n             = expd + 2'd1;
        if (digit == 2'd3) begin
          fv_n    = {glyph, nib[2], nib[1], nib[0]};
          fd_n    = 1'b1;
          dv_n    = 4'b0000;
          state_n = HUNT;
        end
      end else begin
        // Out-of-order in COLLECT is an error; either way a digit 0 starts a fresh frame.
        if (state == COLLECT) begin
          se_n    = 1'b1;
          dv_n    = 4'b0000;
          state_n = HUNT;
        end
        if (digit == 2'd0) begin
          nib_n[0] = glyph;
          dv_n     = 4'b0001;
          expd_n   = 2'd1;
          state_n  = COLLECT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      expd        <= 2'd0;
      nib         <= '0;
      digit_valid <= 4'b0000;
      frame_value <= 16'h0000;
      frame_done  <= 1'b0;
      pattern_err <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      state       <= state_n;
      expd        <= expd_n;
      nib         <= nib_n;
      digit_valid <= dv_n;
      frame_value <= fv_n;
      frame_done  <= fd_n;
      pattern_err <= pe_n;
      seq_err     <= se_n;
    end
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter SETTLE, default 4, consecutive stable sampled cycles needed before a digit is captured (legal range 1-255).
REQ-002 Clk  input  1  single system clock; all state on its rising edge.
REQ-003 Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 anode  input  8  scanned digit select, active-low; bit 0 = LS digit, bit 3 = MS digit, bits 7:4 unused (idle high).
REQ-005 cathode  input  7  segment lines, active-low; bit 0 = a through bit 6 = g.
REQ-006 frame_value  output  16  last complete frame; [3:0] = digit 0 through [15:12] = digit 3.
REQ-007 frame_done  output  1  one-cycle pulse when frame_value updates.
REQ-008 digit_valid  output  4  per-digit captured-this-frame flags.
REQ-009 pattern_err  output  1  one-cycle pulse: a settled segment pattern matched no hex glyph.
REQ-010 seq_err  output  1  one-cycle pulse: illegal anode code or out-of-order digit.

Function
REQ-011 anode and cathode SHALL each pass through a 2-FF synchronizer; all logic below uses the synchronized values.
REQ-012 A settle counter (8 bit, saturating at SETTLE) SHALL clear whenever the synchronized {anode, cathode} differs from the previous cycle, and increment otherwise.
REQ-013 Legal anode codes are FE, FD, FB, F7 (digit 0-3); FF is blank; any other code is illegal.
REQ-014 Capture SHALL occur once per scan slot: the first cycle the counter reaches SETTLE with a legal code; no further capture until anode changes.
REQ-015 Blank (FF) SHALL never capture, SHALL not flag errors, and SHALL clear the settle counter.
REQ-016 Illegal anode code, once settled, SHALL pulse seq_err once per slot and return the FSM to HUNT.
REQ-017 Segment decode (active-high gfedcba after inversion): 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=B, 39=C, 5E=D, 79=E, 71=F.
REQ-018 Any other settled pattern on a legal digit SHALL pulse pattern_err, discard the digit, clear digit_valid, and return the FSM to HUNT.
REQ-019 FSM states: HUNT (wait for digit 0), COLLECT (expect digit k+1 after digit k).
REQ-020 HUNT: valid capture of digit 0 -> store nibble, digit_valid = 0001, go COLLECT expecting 1; capture of digits 1-3 ignored silently.
REQ-021 COLLECT: capture of expected digit -> store nibble, set its digit_valid bit; capture of any other digit -> seq_err pulse, digit_valid cleared, then treat as HUNT (digit 0 restarts a frame in the same cycle).
REQ-022 On capture of digit 3 in COLLECT, frame_value SHALL load all four stored nibbles atomically in the next cycle with frame_done high for exactly that cycle; FSM returns to HUNT, digit_valid clears with the same edge.
REQ-023 Re-capture of the same digit is impossible within one slot (REQ-014); the same digit in two consecutive slots counts as out-of-order.
REQ-024 Latency: frame_done asserts SETTLE+3 cycles after digit 3's final input change (2 sync + SETTLE + 1 register).
REQ-025 pattern_err and seq_err SHALL never both pulse in the same cycle; illegal anode takes precedence.

Reset
REQ-026 Rst_n low SHALL immediately force frame_value=0000, frame_done=0, digit_valid=0000, pattern_err=0, seq_err=0, synchronizers to FF/7F, settle counter 0, FSM HUNT.
REQ-027 Reset mid-frame SHALL discard partial digits; first frame_done after release requires a full 0-1-2-3 sequence.

Verification
REQ-028 Scan digits 0..3 showing 1,2,3,4 (cathode ~06,~5B,~4F,~66), 10 cycles each -> one frame_done, frame_value=4321.
REQ-029 Same scan with 1-cycle FF blank between digits and SETTLE=4 -> identical result; no error pulses.
REQ-030 Digit 2 driven with cathode ~00 (all off) -> pattern_err pulse, no frame_done until next clean 0-3 scan.
REQ-031 Scan order 0,2,3,0,1,2,3 showing 0,1,2,3 -> seq_err at digit 2, then frame_done with frame_value=3210.
REQ-032 anode=FC held 10 cycles -> single seq_err pulse, FSM HUNT; cathode glitch shorter than SETTLE -> no capture.
REQ-033 Rst_n asserted after digits 0,1 captured -> all outputs zero asynchronously; following scan 5,6,7,8 -> frame_value=8765.
